// File: rtl/axi_fsrc_pkg.sv
// Shared types and constants for the FSRC sequencer timing engine.
// Imported by the edge detector and the sequencer core.
package axi_fsrc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        RUN       = 2'd2
    } seq_state_t;

    localparam int SEQ_PERIOD_W = 32;
    localparam int SEQ_ACCUM_W  = 16;

    // A zero period length is treated as a one-cycle period.
    function automatic logic [SEQ_PERIOD_W-1:0] period_len(
        input logic [SEQ_PERIOD_W-1:0] cnt
    );
        return (cnt == '0) ? SEQ_PERIOD_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/axi_fsrc_edge_det.sv
// Rising-edge detector with optional 2-FF synchronizer.
// Events are held off until the pipeline holds post-reset samples.
module axi_fsrc_edge_det
    import axi_fsrc_pkg::*;
#(
    parameter bit SYNC = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic pulse
);

    localparam logic [1:0] FILL = SYNC ? 2'd3 : 2'd1;

    logic       lvl;
    logic       prev;
    logic [1:0] fill;

    generate
        if (SYNC) begin : g_sync
            logic [1:0] sync;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) sync <= '0;
                else         sync <= {sync[0], d};
            end
            assign lvl = sync[1];
        end else begin : g_direct
            assign lvl = d;
        end
    endgenerate

    // A level already high at reset release never looks like an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev <= 1'b0;
            fill <= '0;
        end else begin
            prev <= lvl;
            if (fill != FILL) fill <= fill + 2'd1;
        end
    end

    assign pulse = lvl & ~prev & (fill == FILL);

endmodule

// File: rtl/axi_fsrc_sequencer_core.sv
// FSRC sequencer timing engine: GPIO period updates, trigger pulses,
// TX accumulator reset and one-shot RX start, armed by software start.
module axi_fsrc_sequencer_core
    import axi_fsrc_pkg::*;
#(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              seq_start,
    input  logic                              seq_en,
    input  logic                              seq_ext_trig_en,
    input  logic                              seq_ext_trig,
    input  logic                              ext_trig_in,
    input  logic [31:0]                       gpio_change_cnt,
    input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt,
    input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] second_trig_cnt,
    input  logic [COUNTER_WIDTH-1:0]          rx_delay_cnt,
    input  logic [15:0]                       tx_accum_reset_cnt,
    input  logic [CTRL_WIDTH-1:0]             dut_seq_gpio_w,
    input  logic [NUM_TRIG-1:0]               trig_manual,
    output logic [CTRL_WIDTH-1:0]             dut_seq_gpio,
    output logic [NUM_TRIG-1:0]               trig_out,
    output logic                              tx_accum_reset,
    output logic                              rx_start,
    output logic                              seq_busy
);

    seq_state_t state;
    seq_state_t state_next;

    logic start_ev;
    logic sw_trig_ev;
    logic hw_trig_ev;
    logic trig_ev;

    logic [SEQ_PERIOD_W-1:0]  pcnt;
    logic [SEQ_PERIOD_W-1:0]  last;
    logic [SEQ_ACCUM_W-1:0]   acnt;
    logic [COUNTER_WIDTH-1:0] rcnt;
    logic                     rx_done;

    logic                run_cyc;
    logic                enter_run;
    logic                wrap;
    logic                accum_hit;
    logic                rx_hit;
    logic [NUM_TRIG-1:0] hit;

    axi_fsrc_edge_det #(.SYNC(1'b0)) u_start_ed (
        .clk    (clk),
        .resetn (resetn),
        .d      (seq_start),
        .pulse  (start_ev)
    );

    axi_fsrc_edge_det #(.SYNC(1'b0)) u_sw_trig_ed (
        .clk    (clk),
        .resetn (resetn),
        .d      (seq_ext_trig),
        .pulse  (sw_trig_ev)
    );

    axi_fsrc_edge_det #(.SYNC(1'b1)) u_hw_trig_ed (
        .clk    (clk),
        .resetn (resetn),
        .d      (ext_trig_in),
        .pulse  (hw_trig_ev)
    );

    assign trig_ev   = sw_trig_ev | hw_trig_ev;
    assign last      = period_len(gpio_change_cnt) - SEQ_PERIOD_W'(1);
    // >= keeps the counter bounded if the period shrinks mid-run
    assign wrap      = pcnt >= last;
    assign run_cyc   = (state == RUN) && seq_en;
    assign enter_run = (state != RUN) && (state_next == RUN);
    assign accum_hit = (tx_accum_reset_cnt != '0) &&
                       (acnt == tx_accum_reset_cnt - SEQ_ACCUM_W'(1));
    assign rx_hit    = !rx_done && (rcnt == rx_delay_cnt);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            hit[i] =
                (pcnt == SEQ_PERIOD_W'(first_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH])) ||
                (pcnt == SEQ_PERIOD_W'(second_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]));
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_ev) state_next = seq_ext_trig_en ? WAIT_TRIG : RUN;
            end
            WAIT_TRIG: begin
                if (trig_ev) state_next = RUN;
            end
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!seq_en) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            seq_busy <= 1'b0;
        end else begin
            state    <= state_next;
            seq_busy <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt    <= '0;
            acnt    <= '0;
            rcnt    <= '0;
            rx_done <= 1'b0;
        end else if (enter_run) begin
            pcnt    <= '0;
            acnt    <= '0;
            rcnt    <= '0;
            rx_done <= 1'b0;
        end else if (run_cyc) begin
            pcnt <= wrap ? '0 : pcnt + SEQ_PERIOD_W'(1);
            if (wrap) acnt <= accum_hit ? '0 : acnt + SEQ_ACCUM_W'(1);
            if (rcnt != '1) rcnt <= rcnt + COUNTER_WIDTH'(1);
            if (rx_hit) rx_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dut_seq_gpio   <= '0;
            trig_out       <= '0;
            tx_accum_reset <= 1'b0;
            rx_start       <= 1'b0;
        end else begin
            trig_out       <= ({NUM_TRIG{run_cyc}} & hit) | trig_manual;
            tx_accum_reset <= run_cyc && wrap && accum_hit;
            rx_start       <= run_cyc && rx_hit;
            if (state_next == IDLE) dut_seq_gpio <= '0;
            else if (run_cyc && pcnt == '0) dut_seq_gpio <= dut_seq_gpio_w;
        end
    end

endmodule

// File: tb/tb_axi_fsrc_sequencer_core.sv
// Self-checking bench for axi_fsrc_sequencer_core: directed table,
// corner-case sequences and randomized stimulus against a period model.
module tb_axi_fsrc_sequencer_core;

    logic        clk;
    logic        resetn;
    logic        seq_start;
    logic        seq_en;
    logic        seq_ext_trig_en;
    logic        seq_ext_trig;
    logic        ext_trig_in;
    logic [31:0] gpio_change_cnt;
    logic [15:0] first_trig_cnt;
    logic [15:0] second_trig_cnt;
    logic [3:0]  rx_delay_cnt;
    logic [15:0] tx_accum_reset_cnt;
    logic [39:0] dut_seq_gpio_w;
    logic [3:0]  trig_manual;
    logic [39:0] dut_seq_gpio;
    logic [3:0]  trig_out;
    logic        tx_accum_reset;
    logic        rx_start;
    logic        seq_busy;

    axi_fsrc_sequencer_core dut (
        .clk                (clk),
        .resetn             (resetn),
        .seq_start          (seq_start),
        .seq_en             (seq_en),
        .seq_ext_trig_en    (seq_ext_trig_en),
        .seq_ext_trig       (seq_ext_trig),
        .ext_trig_in        (ext_trig_in),
        .gpio_change_cnt    (gpio_change_cnt),
        .first_trig_cnt     (first_trig_cnt),
        .second_trig_cnt    (second_trig_cnt),
        .rx_delay_cnt       (rx_delay_cnt),
        .tx_accum_reset_cnt (tx_accum_reset_cnt),
        .dut_seq_gpio_w     (dut_seq_gpio_w),
        .trig_manual        (trig_manual),
        .dut_seq_gpio       (dut_seq_gpio),
        .trig_out           (trig_out),
        .tx_accum_reset     (tx_accum_reset),
        .rx_start           (rx_start),
        .seq_busy           (seq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;

    // Period-level reference: run cycle index t, pcnt = t mod L.
    int          m_state;
    int          m_t;
    logic [39:0] m_gpio;
    logic [3:0]  m_trig;
    logic        m_tx;
    logic        m_rx;
    logic        m_busy;
    logic        m_start_prev;
    logic        m_xt_prev;
    logic [1:0]  m_hw;
    logic        m_hw_prev;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state      = M_IDLE;
        m_t          = 0;
        m_gpio       = '0;
        m_trig       = '0;
        m_tx         = 1'b0;
        m_rx         = 1'b0;
        m_busy       = 1'b0;
        m_start_prev = seq_start;
        m_xt_prev    = seq_ext_trig;
        m_hw         = {ext_trig_in, ext_trig_in};
        m_hw_prev    = ext_trig_in;
    endtask

    task automatic model_edge();
        bit s_ev, sw_ev, hw_ev, run;
        int L, p, n, f, s;
        s_ev         = seq_start && !m_start_prev;
        m_start_prev = seq_start;
        sw_ev        = seq_ext_trig && !m_xt_prev;
        m_xt_prev    = seq_ext_trig;
        hw_ev        = m_hw[1] && !m_hw_prev;
        m_hw_prev    = m_hw[1];
        m_hw         = {m_hw[0], ext_trig_in};
        L = (gpio_change_cnt == 0) ? 1 : int'(gpio_change_cnt);
        n = int'(tx_accum_reset_cnt);
        run    = (m_state == M_RUN) && seq_en;
        m_trig = trig_manual;
        m_tx   = 1'b0;
        m_rx   = 1'b0;
        if (run) begin
            p = m_t % L;
            if (p == 0) m_gpio = dut_seq_gpio_w;
            for (int i = 0; i < 4; i++) begin
                f = int'(first_trig_cnt[i*4 +: 4]);
                s = int'(second_trig_cnt[i*4 +: 4]);
                if (p == f || p == s) m_trig[i] = 1'b1;
            end
            if (p == L - 1 && n != 0 && ((m_t + 1) / L) % n == 0)
                m_tx = 1'b1;
            if (m_t == int'(rx_delay_cnt)) m_rx = 1'b1;
            m_t++;
        end
        if (!seq_en) begin
            m_state = M_IDLE;
        end else if (m_state == M_IDLE && s_ev) begin
            m_state = seq_ext_trig_en ? M_WAIT : M_RUN;
            m_t = 0;
        end else if (m_state == M_WAIT && (sw_ev || hw_ev)) begin
            m_state = M_RUN;
            m_t = 0;
        end
        if (m_state == M_IDLE) m_gpio = '0;
        m_busy = (m_state != M_IDLE);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", 64'(seq_busy), 64'(m_busy));
        chk("gpio", 64'(dut_seq_gpio), 64'(m_gpio));
        chk("trig", 64'(trig_out), 64'(m_trig));
        chk("tx_rst", 64'(tx_accum_reset), 64'(m_tx));
        chk("rx_start", 64'(rx_start), 64'(m_rx));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(seq_busy), 64'd0);
        chk({tag, "_gpio"}, 64'(dut_seq_gpio), 64'd0);
        chk({tag, "_trig"}, 64'(trig_out), 64'd0);
        chk({tag, "_tx"}, 64'(tx_accum_reset), 64'd0);
        chk({tag, "_rx"}, 64'(rx_start), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (4) step();
    endtask

    typedef struct {
        logic [31:0] l;
        logic [15:0] f;
        logic [15:0] s;
        logic [15:0] tx;
        logic [3:0]  rx;
        logic [3:0]  man;
        int          c;
        int          e0, e1, e2, e3;
        int          etx;
        int          erx;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int cnt[4];
        int ctx, crx, at;
        bit seen;
        logic [39:0] w;

        checks   = 0;
        failures = 0;
        resetn          = 1'b1;
        seq_start       = 1'b1;
        seq_en          = 1'b1;
        seq_ext_trig_en = 1'b0;
        seq_ext_trig    = 1'b0;
        ext_trig_in     = 1'b0;
        gpio_change_cnt = 32'd10;
        first_trig_cnt  = 16'hFFFF;
        second_trig_cnt = 16'hFFFF;
        rx_delay_cnt    = 4'hF;
        tx_accum_reset_cnt = 16'd0;
        dut_seq_gpio_w  = 40'hA5;
        trig_manual     = 4'h0;

        tbl[0] = '{32'd8, 16'hF932, 16'hF935, 16'd0, 4'd0, 4'h8,
                   32, 8, 4, 0, 32, 0, 1};
        tbl[1] = '{32'd4, 16'hF430, 16'hF431, 16'd3, 4'd6, 4'h0,
                   48, 24, 12, 0, 0, 4, 1};
        tbl[2] = '{32'd4, 16'hFF01, 16'hFF02, 16'd0, 4'd15, 4'h0,
                   12, 6, 3, 0, 0, 0, 0};
        tbl[3] = '{32'd0, 16'hFF10, 16'hFF10, 16'd1, 4'd2, 4'h0,
                   10, 10, 0, 0, 0, 10, 1};

        // Start held high through reset release is not a start.
        #2;
        do_reset();
        repeat (3) step();
        chk("start_at_reset", 64'(seq_busy), 64'd0);

        // Basic run, GPIO sampled once per period.
        seq_start = 1'b0;
        step();
        seq_start = 1'b1;
        step();
        step();
        chk("gpio_first", 64'(dut_seq_gpio), 64'hA5);
        chk("busy_run", 64'(seq_busy), 64'd1);
        for (int n = 3; n <= 12; n++) begin
            if (n == 4) dut_seq_gpio_w = 40'h5A;
            if (n == 8) seq_start = 1'b0;
            if (n == 9) seq_start = 1'b1;
            step();
            if (n == 7) chk("gpio_mid", 64'(dut_seq_gpio), 64'hA5);
            if (n == 12) chk("gpio_next", 64'(dut_seq_gpio), 64'h5A);
        end

        // Table of per-run pulse counts.
        for (int k = 0; k < 4; k++) begin
            seq_en    = 1'b0;
            seq_start = 1'b0;
            step();
            gpio_change_cnt    = tbl[k].l;
            first_trig_cnt     = tbl[k].f;
            second_trig_cnt    = tbl[k].s;
            tx_accum_reset_cnt = tbl[k].tx;
            rx_delay_cnt       = tbl[k].rx;
            trig_manual        = tbl[k].man;
            dut_seq_gpio_w     = 40'h0F0F0F0F0F;
            seq_en = 1'b1;
            step();
            seq_start = 1'b1;
            step();
            cnt = '{0, 0, 0, 0};
            ctx = 0;
            crx = 0;
            for (int c = 0; c < tbl[k].c; c++) begin
                step();
                for (int i = 0; i < 4; i++) cnt[i] += int'(trig_out[i]);
                ctx += int'(tx_accum_reset);
                crx += int'(rx_start);
            end
            chk($sformatf("tbl%0d_trig0", k), 64'(cnt[0]), 64'(tbl[k].e0));
            chk($sformatf("tbl%0d_trig1", k), 64'(cnt[1]), 64'(tbl[k].e1));
            chk($sformatf("tbl%0d_trig2", k), 64'(cnt[2]), 64'(tbl[k].e2));
            chk($sformatf("tbl%0d_trig3", k), 64'(cnt[3]), 64'(tbl[k].e3));
            chk($sformatf("tbl%0d_tx", k), 64'(ctx), 64'(tbl[k].etx));
            chk($sformatf("tbl%0d_rx", k), 64'(crx), 64'(tbl[k].erx));
        end

        // External trigger path.
        seq_en      = 1'b0;
        seq_start   = 1'b0;
        trig_manual = 4'h0;
        step();
        seq_ext_trig_en = 1'b1;
        gpio_change_cnt = 32'd8;
        first_trig_cnt  = 16'hFFF0;
        second_trig_cnt = 16'hFFF0;
        dut_seq_gpio_w  = 40'h33;
        seq_en = 1'b1;
        step();
        seq_start = 1'b1;
        step();
        step();
        chk("wait_busy", 64'(seq_busy), 64'd1);
        chk("wait_gpio", 64'(dut_seq_gpio), 64'd0);
        #3 ext_trig_in = 1'b1;
        seen = 1'b0;
        at = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) ext_trig_in = 1'b0;
            step();
            if (!seen && trig_out[0]) begin
                seen = 1'b1;
                at = k;
            end
        end
        chk("ext_trig_seen", 64'(seen), 64'd1);
        chk("ext_trig_lat_ok", 64'(at >= 1 && at <= 4), 64'd1);
        seq_start = 1'b0;
        step();
        seq_start = 1'b1;
        repeat (10) step();

        // seq_en low wins over a simultaneous trigger.
        seq_en = 1'b0;
        step();
        seq_en    = 1'b1;
        seq_start = 1'b0;
        step();
        seq_start = 1'b1;
        repeat (2) step();
        seq_en       = 1'b0;
        seq_ext_trig = 1'b1;
        step();
        chk_zero("en_drop");
        seq_en = 1'b1;
        repeat (4) step();
        chk("en_drop_idle", 64'(seq_busy), 64'd0);

        // Zero period length: GPIO follows every cycle.
        seq_en = 1'b0;
        seq_start = 1'b0;
        seq_ext_trig = 1'b0;
        step();
        seq_ext_trig_en = 1'b0;
        gpio_change_cnt = 32'd0;
        seq_en = 1'b1;
        step();
        seq_start = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            w = {8'($urandom), $urandom};
            dut_seq_gpio_w = w;
            step();
            chk("gpio_l1", 64'(dut_seq_gpio), 64'(w));
        end

        // Randomized episodes against the model.
        for (int e = 0; e < 20; e++) begin
            seq_en = 1'b0;
            step();
            gpio_change_cnt    = 32'($urandom_range(0, 12));
            first_trig_cnt     = 16'($urandom);
            second_trig_cnt    = 16'($urandom);
            tx_accum_reset_cnt = 16'($urandom_range(0, 4));
            rx_delay_cnt       = 4'($urandom);
            seq_ext_trig_en    = 1'($urandom);
            for (int c = 0; c < 80; c++) begin
                seq_en = ($urandom_range(0, 29) != 0);
                if ($urandom_range(0, 3) == 0) seq_start = ~seq_start;
                if ($urandom_range(0, 3) == 0) seq_ext_trig = ~seq_ext_trig;
                if ($urandom_range(0, 7) == 0) ext_trig_in = ~ext_trig_in;
                trig_manual    = 4'($urandom);
                dut_seq_gpio_w = {8'($urandom), $urandom};
                step();
            end
        end

        // Asynchronous reset in the middle of a run.
        seq_en = 1'b0;
        seq_start = 1'b0;
        seq_ext_trig = 1'b0;
        ext_trig_in = 1'b0;
        trig_manual = 4'h0;
        step();
        seq_ext_trig_en = 1'b0;
        gpio_change_cnt = 32'd5;
        first_trig_cnt  = 16'hFFF1;
        second_trig_cnt = 16'hFFF1;
        dut_seq_gpio_w  = 40'h12_3456_789A;
        seq_en = 1'b1;
        step();
        seq_start = 1'b1;
        repeat (4) step();
        chk("busy_before_rst", 64'(seq_busy), 64'd1);
        #2;
        do_reset();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
